// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store memory initiator.
//   lsu_state_e  : initiator FSM states (IDLE, ACCESS, RESP).
//   DWORD_BYTES  : bytes per memory word (one doubleword).
//   ALIGN_BITS   : low address bits that must be zero for a doubleword access.
//   addr_legal() : 1 when an address is doubleword aligned and inside memory.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam int unsigned DWORD_BYTES = 8;
  localparam int unsigned ALIGN_BITS  = 3;

  function automatic logic addr_legal(input logic [63:0] addr,
                                      input logic [63:0] mem_bytes);
    return (addr[ALIGN_BITS-1:0] == '0) && (addr < mem_bytes);
  endfunction

endpackage

// File: rtl/lsu_latency_counter.sv
// lsu_latency_counter: measures the fixed memory access window.
//   clk, rst_n : clock, asynchronous active-low reset.
//   i_load     : restart the window (count returns to 0).
//   i_count    : advance while the access is in progress.
//   o_done     : high in the last cycle of the window (count == MEM_LATENCY-1).
// MEM_LATENCY must lie in 1..15 so the count fits in four bits.
module lsu_latency_counter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_count,
  output logic o_done
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LATENCY - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same clock edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_count && !o_done) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_done = (r_count == LAST);

endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: LDUR/STUR initiator between the memory stage and the
// doubleword data memory. One request is outstanding at a time.
//   clk, rst_n                 : clock, asynchronous active-low reset.
//   i_req_valid / o_req_ready  : request handshake (accepted in IDLE only).
//   i_req_write                : 1 = store, 0 = load.
//   i_req_address, i_req_wdata : byte address and store data.
//   o_rsp_valid / i_rsp_ready  : response handshake.
//   o_rsp_rdata, o_rsp_fault   : load data (0 for stores/faults) and fault flag.
//   o_mem_address, o_mem_wdata : memory address/data, held outside ACCESS.
//   o_mem_read, o_mem_write    : memory strobes, high only during ACCESS.
//   i_mem_rdata                : memory read data.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned MEM_BYTES   = 128,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_address,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_fault,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_next;
  logic              r_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_fault;

  logic w_accept;
  logic w_legal;
  logic w_in_access;
  logic w_done;

  assign w_accept    = (r_state == IDLE) && i_req_valid;
  assign w_legal     = addr_legal(64'(i_req_address), 64'(MEM_BYTES));
  assign w_in_access = (r_state == ACCESS);

  lsu_latency_counter #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_latency_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_count (w_in_access),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Strobes and handshake flags decode straight from the state register, so
  // an asynchronous reset in the middle of an access drops them at once.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    o_req_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_state_next = w_legal ? ACCESS : RESP;
      end
      ACCESS: begin
        o_mem_read  = !r_write;
        o_mem_write = r_write;
        if (w_done) w_state_next = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Memory-facing registers load only for legal requests, so a faulted request
  // leaves the address/data lines exactly as the last real access left them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write       <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_fault   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_rdata <= '0;
      r_rsp_fault <= !w_legal;
      if (w_legal) begin
        r_write       <= i_req_write;
        r_mem_address <= i_req_address;
        r_mem_wdata   <= i_req_wdata;
      end
    end else if (w_in_access && w_done && !r_write) begin
      r_rsp_rdata <= i_mem_rdata;
    end
  end

  assign o_mem_address = r_mem_address;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_fault   = r_rsp_fault;

endmodule
